cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, maximum cycles in any memory-wait state before abort.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  4  instruction[15:12] from the instruction register.
REQ-005 opcode_ext  in  4  instruction[7:4] from the instruction register.
REQ-006 cond_true  in  1  condition-code evaluation for Bcond/Jcond, valid in EXEC.
REQ-007 mem_ready  in  1  memory acknowledge for the current mem_req.
REQ-008 ir_en  out  1  instruction-register load enable.
REQ-009 pc_en / pc_sel  out  1/2  PC update; pc_sel 0=PC+1, 1=PC+disp, 2=Rsrc.
REQ-010 mem_req / mem_we / addr_sel  out  1/1/1  memory request, write strobe, address source (0=PC, 1=Raddr).
REQ-011 reg_we / wb_sel / imm_sel / flag_we  out  1/2/1/1  register write, write-back source (0=ALU, 1=mem, 2=PC+1), immediate operand select, PSR flag write.
REQ-012 illegal / timeout  out  1/1  one-cycle error pulses.

Function
REQ-013 States: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB; state encoding is 3-bit binary.
REQ-014 FETCH: mem_req=1, addr_sel=0; stay until mem_ready=1; on exit assert ir_en=1 for exactly one cycle; next DECODE.
REQ-015 DECODE: all enables 0; classify opcode/opcode_ext; next EXEC, except an illegal encoding -> illegal=1 for one cycle, pc_en=1, pc_sel=0, next FETCH.
REQ-016 R-type (opcode 0000) and immediate (opcode not 0000/0100/1100/1111): EXEC asserts reg_we=1, wb_sel=0, flag_we=1, imm_sel=(opcode!=0000), pc_en=1, pc_sel=0; next FETCH; CMP (ext/opcode 1011) suppresses reg_we.
REQ-017 LOAD (0100/0000): EXEC -> MEM_RD with mem_req=1, addr_sel=1 until mem_ready -> WB: reg_we=1, wb_sel=1, pc_en=1, pc_sel=0 -> FETCH.
REQ-018 STOR (0100/0100): EXEC -> MEM_WR with mem_req=1, mem_we=1, addr_sel=1 until mem_ready; exit cycle pc_en=1, pc_sel=0 -> FETCH.
REQ-019 Bcond (1100): EXEC pc_en=1, pc_sel=cond_true?1:0 -> FETCH.
REQ-020 Jcond (0100/1100): EXEC pc_en=1, pc_sel=cond_true?2:0 -> FETCH.
REQ-021 JAL (0100/1000): EXEC reg_we=1, wb_sel=2, pc_en=1, pc_sel=2 -> FETCH.
REQ-022 Opcode 1111 and undefined 0100 extensions are illegal per REQ-015.
REQ-023 Wait counter, 4-bit, cleared on entry to FETCH/MEM_RD/MEM_WR, increments each wait cycle; mem_ready=0 at count MEM_TIMEOUT -> timeout=1, drop mem_req, pc_en=0, return to FETCH (PC unchanged, fetch retried).
REQ-024 mem_ready asserted in the same cycle mem_req first rises is accepted (zero-wait memory); mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
REQ-025 mem_we never asserted outside MEM_WR; reg_we and mem_we never both 1.
REQ-026 Instruction latency with zero-wait memory: ALU/branch/jump 3 cycles, LOAD 5, STOR 4.
REQ-027 All outputs are registered-free Moore decode of state plus latched class; no output depends combinationally on opcode outside DECODE/EXEC.

Reset
REQ-028 rst_n=0 forces state FETCH, wait counter 0, latched class 0, all outputs 0 immediately, independent of clk.
REQ-029 Reset mid-memory-access drops mem_req/mem_we in the same cycle; after release, FETCH begins on the first rising clk edge.

Structure
REQ-030 State encoding, instruction-class enum, opcode/extension constants and pc_sel/wb_sel codes belong in shared package cpu_pkg.
REQ-031 One sub-module, cpu_decode (combinational opcode/opcode_ext -> instruction class + illegal), instantiated once.

Verification
REQ-032 Reset then ADD (0000/0101), mem_ready=1 always -> ir_en at cycle 1, reg_we+flag_we+pc_en in cycle 3, back to FETCH.
REQ-033 LOAD with mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles, reg_we with wb_sel=1 exactly once, total 8 cycles.
REQ-034 Bcond with cond_true=1 then cond_true=0 -> pc_sel=1 then pc_sel=0, reg_we never asserted.
REQ-035 Opcode 1111 -> illegal pulse one cycle in DECODE, pc_en=1, no reg_we/mem_we, next FETCH.
REQ-036 FETCH with mem_ready held 0 -> timeout pulse after 15 wait cycles, mem_req drops, pc_en=0, FETCH re-entered.
REQ-037 rst_n pulsed low during MEM_WR -> mem_we=0 immediately, state FETCH, outputs 0 until release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU controller:
// FSM states, instruction classes, opcode constants and mux select codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE  = 4'd0,
    C_ALU_R = 4'd1,
    C_ALU_I = 4'd2,
    C_CMP_R = 4'd3,
    C_CMP_I = 4'd4,
    C_LOAD  = 4'd5,
    C_STOR  = 4'd6,
    C_BCOND = 4'd7,
    C_JCOND = 4'd8,
    C_JAL   = 4'd9
  } iclass_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_EXT   = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_RSVD  = 4'b1111;
  localparam logic [3:0] OP_CMPI  = 4'b1011;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_CMP   = 4'b1011;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_DISP = 2'd1;
  localparam logic [1:0] PC_RSRC = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC1 = 2'd2;

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       imm_sel;
    logic       flag_we;
    logic       illegal;
    logic       timeout;
  } ctrl_t;

  // States in which the controller waits on mem_ready and the timeout counter runs.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction/memory handshake and datapath control bundle between the
// controller (master) and the datapath/memory side (slave).
interface cpu_controller_if;
  logic [3:0] opcode;
  logic [3:0] opcode_ext;
  logic       cond_true;
  logic       mem_ready;

  logic       ir_en;
  logic       pc_en;
  logic [1:0] pc_sel;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       reg_we;
  logic [1:0] wb_sel;
  logic       imm_sel;
  logic       flag_we;
  logic       illegal;
  logic       timeout;

  modport master (
    input  opcode, opcode_ext, cond_true, mem_ready,
    output ir_en, pc_en, pc_sel, mem_req, mem_we, addr_sel,
           reg_we, wb_sel, imm_sel, flag_we, illegal, timeout
  );

  modport slave (
    output opcode, opcode_ext, cond_true, mem_ready,
    input  ir_en, pc_en, pc_sel, mem_req, mem_we, addr_sel,
           reg_we, wb_sel, imm_sel, flag_we, illegal, timeout
  );
endinterface

// File: rtl/cpu_decode.sv
// Combinational instruction classifier: opcode/opcode_ext -> class + illegal flag.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] opcode_ext,
  output iclass_t    iclass,
  output logic       illegal
);

  always_comb begin
    iclass  = C_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (opcode_ext == EXT_CMP) iclass = C_CMP_R;
        else                       iclass = C_ALU_R;
      end
      OP_EXT: begin
        case (opcode_ext)
          EXT_LOAD:  iclass = C_LOAD;
          EXT_STOR:  iclass = C_STOR;
          EXT_JCOND: iclass = C_JCOND;
          EXT_JAL:   iclass = C_JAL;
          default:   illegal = 1'b1;
        endcase
      end
      OP_BCOND: iclass = C_BCOND;
      OP_RSVD:  illegal = 1'b1;
      OP_CMPI:  iclass = C_CMP_I;
      default:  iclass = C_ALU_I;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/write-back
// sequencing with a memory-wait timeout that aborts back to FETCH.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_controller_if.master  bus
);

  localparam logic [3:0] TMO_CNT = 4'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  iclass_t    cls;
  iclass_t    dec_cls;
  logic       dec_ill;
  logic [3:0] wait_cnt;
  logic       tmo;
  ctrl_t      ctl;
  ctrl_t      ctl_out;

  cpu_decode u_decode (
    .opcode     (bus.opcode),
    .opcode_ext (bus.opcode_ext),
    .iclass     (dec_cls),
    .illegal    (dec_ill)
  );

  assign tmo = is_mem_wait(state) && !bus.mem_ready && (wait_cnt == TMO_CNT);

  // State, latched class and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      cls      <= C_NONE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) cls <= dec_cls;
      // A timeout re-enters FETCH from FETCH, so it must clear the count too.
      if (is_mem_wait(state_nxt) && ((state_nxt != state) || tmo))
        wait_cnt <= '0;
      else if (is_mem_wait(state) && !bus.mem_ready)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (bus.mem_ready) state_nxt = S_DECODE;
        else if (tmo)      state_nxt = S_FETCH;
      end
      S_DECODE: begin
        if (dec_ill) state_nxt = S_FETCH;
        else         state_nxt = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          C_LOAD:  state_nxt = S_MEM_RD;
          C_STOR:  state_nxt = S_MEM_WR;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        if (bus.mem_ready) state_nxt = S_WB;
        else if (tmo)      state_nxt = S_FETCH;
      end
      S_MEM_WR: begin
        if (bus.mem_ready || tmo) state_nxt = S_FETCH;
      end
      S_WB:    state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_req = 1'b1;
        ctl.ir_en   = bus.mem_ready;
      end
      S_DECODE: begin
        if (dec_ill) begin
          ctl.illegal = 1'b1;
          ctl.pc_en   = 1'b1;
          ctl.pc_sel  = PC_INC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_ALU_R, C_ALU_I, C_CMP_R, C_CMP_I: begin
            ctl.reg_we  = (cls == C_ALU_R) || (cls == C_ALU_I);
            ctl.wb_sel  = WB_ALU;
            ctl.flag_we = 1'b1;
            ctl.imm_sel = (cls == C_ALU_I) || (cls == C_CMP_I);
            ctl.pc_en   = 1'b1;
            ctl.pc_sel  = PC_INC;
          end
          C_BCOND: begin
            ctl.pc_en  = 1'b1;
            ctl.pc_sel = bus.cond_true ? PC_DISP : PC_INC;
          end
          C_JCOND: begin
            ctl.pc_en  = 1'b1;
            ctl.pc_sel = bus.cond_true ? PC_RSRC : PC_INC;
          end
          C_JAL: begin
            ctl.reg_we = 1'b1;
            ctl.wb_sel = WB_PC1;
            ctl.pc_en  = 1'b1;
            ctl.pc_sel = PC_RSRC;
          end
          default: ;
        endcase
      end
      S_MEM_RD: begin
        ctl.mem_req  = 1'b1;
        ctl.addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_req  = 1'b1;
        ctl.mem_we   = 1'b1;
        ctl.addr_sel = 1'b1;
        ctl.pc_en    = bus.mem_ready;
        ctl.pc_sel   = PC_INC;
      end
      S_WB: begin
        ctl.reg_we = 1'b1;
        ctl.wb_sel = WB_MEM;
        ctl.pc_en  = 1'b1;
        ctl.pc_sel = PC_INC;
      end
      default: ;
    endcase
    // An aborted access drops every strobe and leaves the PC alone.
    if (tmo) begin
      ctl         = '0;
      ctl.timeout = 1'b1;
    end
  end

  // Reset blanks the outputs combinationally, without waiting for a clock.
  assign ctl_out = rst_n ? ctl : '0;

  assign bus.ir_en    = ctl_out.ir_en;
  assign bus.pc_en    = ctl_out.pc_en;
  assign bus.pc_sel   = ctl_out.pc_sel;
  assign bus.mem_req  = ctl_out.mem_req;
  assign bus.mem_we   = ctl_out.mem_we;
  assign bus.addr_sel = ctl_out.addr_sel;
  assign bus.reg_we   = ctl_out.reg_we;
  assign bus.wb_sel   = ctl_out.wb_sel;
  assign bus.imm_sel  = ctl_out.imm_sel;
  assign bus.flag_we  = ctl_out.flag_we;
  assign bus.illegal  = ctl_out.illegal;
  assign bus.timeout  = ctl_out.timeout;

endmodule

// File: tb/tb_cpu_controller.sv
// Cycle-accurate scoreboard bench for cpu_controller: each driven cycle pushes
// the expected output vector, which a negedge monitor pops and compares.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_controller_if bus ();

  cpu_controller #(.MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Vector order: ir_en pc_en pc_sel mem_req mem_we addr_sel reg_we wb_sel imm_sel flag_we illegal timeout
  function automatic logic [13:0] ex(input logic ir, input logic pce, input logic [1:0] pcs,
                                     input logic mreq, input logic mwe, input logic asel,
                                     input logic rwe, input logic [1:0] wbs, input logic imm,
                                     input logic fwe, input logic ill, input logic to);
    return {ir, pce, pcs, mreq, mwe, asel, rwe, wbs, imm, fwe, ill, to};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [13:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.ir_en, bus.pc_en, bus.pc_sel, bus.mem_req, bus.mem_we, bus.addr_sel,
             bus.reg_we, bus.wb_sel, bus.imm_sel, bus.flag_we, bus.illegal, bus.timeout};
      check_eq(e.tag, 32'(got), 32'(e.v));
    end
  end

  // One clock cycle: drive inputs, record expected outputs, advance to edge+1.
  task automatic step(input string tag, input logic rdy, input logic cond, input logic [13:0] v);
    bus.mem_ready = rdy;
    bus.cond_true = cond;
    sb.push_back('{tag, v});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag, input logic [3:0] op, input logic [3:0] ext);
    bus.opcode     = op;
    bus.opcode_ext = ext;
    step({tag, ".fetch"}, 1'b1, 1'b0, ex(1,0,2'd0,1,0,0,0,2'd0,0,0,0,0));
    step({tag, ".dec"},   1'b1, 1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog sim_time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.opcode     = 4'b0000;
    bus.opcode_ext = 4'b0000;
    bus.cond_true  = 1'b0;
    bus.mem_ready  = 1'b1;
    @(posedge clk);
    #1;
    step("rst.a", 1'b1, 1'b0, '0);
    step("rst.b", 1'b1, 1'b0, '0);
    rst_n = 1'b1;

    // ADD, SUBI-style immediate, CMP and CMPI
    fetch_decode("add", 4'b0000, 4'b0101);
    step("add.ex",  1'b1, 1'b0, ex(0,1,2'd0,0,0,0,1,2'd0,0,1,0,0));
    fetch_decode("addi", 4'b0101, 4'b0011);
    step("addi.ex", 1'b1, 1'b0, ex(0,1,2'd0,0,0,0,1,2'd0,1,1,0,0));
    fetch_decode("cmp", 4'b0000, 4'b1011);
    step("cmp.ex",  1'b1, 1'b0, ex(0,1,2'd0,0,0,0,0,2'd0,0,1,0,0));
    fetch_decode("cmpi", 4'b1011, 4'b0000);
    step("cmpi.ex", 1'b1, 1'b0, ex(0,1,2'd0,0,0,0,0,2'd0,1,1,0,0));

    // Branches and jumps
    fetch_decode("bc1", 4'b1100, 4'b0000);
    step("bc1.ex", 1'b1, 1'b1, ex(0,1,2'd1,0,0,0,0,2'd0,0,0,0,0));
    fetch_decode("bc0", 4'b1100, 4'b0000);
    step("bc0.ex", 1'b1, 1'b0, ex(0,1,2'd0,0,0,0,0,2'd0,0,0,0,0));
    fetch_decode("jc1", 4'b0100, 4'b1100);
    step("jc1.ex", 1'b1, 1'b1, ex(0,1,2'd2,0,0,0,0,2'd0,0,0,0,0));
    fetch_decode("jc0", 4'b0100, 4'b1100);
    step("jc0.ex", 1'b1, 1'b0, ex(0,1,2'd0,0,0,0,0,2'd0,0,0,0,0));
    fetch_decode("jal", 4'b0100, 4'b1000);
    step("jal.ex", 1'b1, 1'b0, ex(0,1,2'd2,0,0,0,1,2'd2,0,0,0,0));

    // LOAD with three wait cycles, then zero-wait LOAD
    fetch_decode("ld3", 4'b0100, 4'b0000);
    step("ld3.ex", 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++)
      step("ld3.wait", 1'b0, 1'b0, ex(0,0,2'd0,1,0,1,0,2'd0,0,0,0,0));
    step("ld3.rdy", 1'b1, 1'b0, ex(0,0,2'd0,1,0,1,0,2'd0,0,0,0,0));
    step("ld3.wb",  1'b1, 1'b0, ex(0,1,2'd0,0,0,0,1,2'd1,0,0,0,0));
    fetch_decode("ld0", 4'b0100, 4'b0000);
    step("ld0.ex",  1'b1, 1'b0, '0);
    step("ld0.rdy", 1'b1, 1'b0, ex(0,0,2'd0,1,0,1,0,2'd0,0,0,0,0));
    step("ld0.wb",  1'b1, 1'b0, ex(0,1,2'd0,0,0,0,1,2'd1,0,0,0,0));

    // STOR zero-wait and with two wait cycles
    fetch_decode("st0", 4'b0100, 4'b0100);
    step("st0.ex",  1'b1, 1'b0, '0);
    step("st0.rdy", 1'b1, 1'b0, ex(0,1,2'd0,1,1,1,0,2'd0,0,0,0,0));
    fetch_decode("st2", 4'b0100, 4'b0100);
    step("st2.ex",  1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++)
      step("st2.wait", 1'b0, 1'b0, ex(0,0,2'd0,1,1,1,0,2'd0,0,0,0,0));
    step("st2.rdy", 1'b1, 1'b0, ex(0,1,2'd0,1,1,1,0,2'd0,0,0,0,0));

    // Illegal encodings abort in DECODE
    bus.opcode = 4'b1111;
    step("ill.fetch", 1'b1, 1'b0, ex(1,0,2'd0,1,0,0,0,2'd0,0,0,0,0));
    step("ill.dec",   1'b1, 1'b0, ex(0,1,2'd0,0,0,0,0,2'd0,0,0,1,0));
    bus.opcode     = 4'b0100;
    bus.opcode_ext = 4'b0001;
    step("ilx.fetch", 1'b1, 1'b0, ex(1,0,2'd0,1,0,0,0,2'd0,0,0,0,0));
    step("ilx.dec",   1'b1, 1'b0, ex(0,1,2'd0,0,0,0,0,2'd0,0,0,1,0));

    // FETCH timeout after 15 wait cycles, then the retried fetch succeeds
    bus.opcode     = 4'b0000;
    bus.opcode_ext = 4'b0101;
    for (int i = 0; i < 15; i++)
      step("ft.wait", 1'b0, 1'b0, ex(0,0,2'd0,1,0,0,0,2'd0,0,0,0,0));
    step("ft.tmo", 1'b0, 1'b0, ex(0,0,2'd0,0,0,0,0,2'd0,0,0,0,1));
    fetch_decode("ft.add", 4'b0000, 4'b0101);
    step("ft.add.ex", 1'b1, 1'b0, ex(0,1,2'd0,0,0,0,1,2'd0,0,1,0,0));

    // MEM_RD timeout; counter must restart on MEM_RD entry after a slow fetch
    bus.opcode     = 4'b0100;
    bus.opcode_ext = 4'b0000;
    for (int i = 0; i < 5; i++)
      step("rt.fwait", 1'b0, 1'b0, ex(0,0,2'd0,1,0,0,0,2'd0,0,0,0,0));
    step("rt.fetch", 1'b1, 1'b0, ex(1,0,2'd0,1,0,0,0,2'd0,0,0,0,0));
    step("rt.dec",   1'b1, 1'b0, '0);
    step("rt.ex",    1'b1, 1'b0, '0);
    for (int i = 0; i < 15; i++)
      step("rt.wait", 1'b0, 1'b0, ex(0,0,2'd0,1,0,1,0,2'd0,0,0,0,0));
    step("rt.tmo", 1'b0, 1'b0, ex(0,0,2'd0,0,0,0,0,2'd0,0,0,0,1));
    step("rt.refetch", 1'b1, 1'b0, ex(1,0,2'd0,1,0,0,0,2'd0,0,0,0,0));
    step("rt.dec2",    1'b1, 1'b0, '0);
    step("rt.ex2",     1'b1, 1'b0, '0);
    step("rt.rdy",     1'b1, 1'b0, ex(0,0,2'd0,1,0,1,0,2'd0,0,0,0,0));
    step("rt.wb",      1'b1, 1'b0, ex(0,1,2'd0,0,0,0,1,2'd1,0,0,0,0));

    // Asynchronous reset in the middle of MEM_WR
    fetch_decode("rw", 4'b0100, 4'b0100);
    step("rw.ex",   1'b1, 1'b0, '0);
    step("rw.wait", 1'b0, 1'b0, ex(0,0,2'd0,1,1,1,0,2'd0,0,0,0,0));
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rw.rst.mem_we",  32'(bus.mem_we), 32'd0);
    check_eq("rw.rst.mem_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk);
    #1;
    step("rw.hold0", 1'b0, 1'b0, '0);
    step("rw.hold1", 1'b1, 1'b0, '0);
    rst_n = 1'b1;
    fetch_decode("rw.add", 4'b0000, 4'b0101);
    step("rw.add.ex", 1'b1, 1'b0, ex(0,1,2'd0,0,0,0,1,2'd0,0,1,0,0));

    repeat (2) @(posedge clk);
    check_eq("sb.drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
